// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W      = 115,
    parameter bit          SKID        = 1'b1,
    parameter bit          BUBBLE_ZERO = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_count,
    input  logic              clr_stall
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  stall_q,      stall_d;

    logic accept, out_xfer;
    logic load_main, load_skid, move_skid;

    // With a skid entry, in_ready comes straight from a flop so no
    // combinational path runs from out_ready back upstream.
    assign in_ready = SKID ? !skid_valid_q : (out_ready | !main_valid_q);
    assign accept   = in_valid & in_ready & !flush;
    assign out_xfer = main_valid_q & out_ready;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        if (SKID) begin
            if (skid_valid_q) begin
                if (out_xfer) begin
                    move_skid    = 1'b1;
                    skid_valid_d = 1'b0;
                end
            end else if (accept) begin
                if (!main_valid_q || out_xfer) begin
                    load_main    = 1'b1;
                    main_valid_d = 1'b1;
                end else begin
                    load_skid    = 1'b1;
                    skid_valid_d = 1'b1;
                end
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (accept) begin
                load_main    = 1'b1;
                main_valid_d = 1'b1;
            end else if (out_xfer) begin
                main_valid_d = 1'b0;
            end
        end
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            move_skid    = 1'b0;
        end
    end

    // Data registers only change on a real load, keeping enables clean for gating.
    assign main_data_d = load_main ? in_data : (move_skid ? skid_data_q : main_data_q);
    assign skid_data_d = load_skid ? in_data : skid_data_q;

    always_comb begin
        stall_d = stall_q;
        if (clr_stall) begin
            stall_d = '0;
        end else if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            // NOTE: data registers are reset too, so a bubble never exposes stale X payload bits.
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            stall_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_data    = BUBBLE_ZERO ? (main_data_q & {DATA_W{main_valid_q}}) : main_data_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a no-skid instance share
// stimulus; each is compared every cycle against a queue-based FIFO model.
module tb_pipe_stage_reg;

    localparam int DW = 40;

    logic          clock = 1'b0;
    logic          clr;
    logic          in_valid, flush, out_ready, clr_stall;
    logic [DW-1:0] in_data;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_stall;
    logic          n_in_ready, n_out_valid;
    logic [DW-1:0] n_out_data;
    logic [15:0]   n_stall;

    int n_cmp = 0;
    int n_mis = 0;

    logic [DW-1:0] q_s[$];
    logic [DW-1:0] q_n[$];
    int            st_s, st_n;

    always #5 clock = ~clock;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .BUBBLE_ZERO(1'b1), .CNT_W(4)) u_skid (
        .clock(clock), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .stall_count(s_stall), .clr_stall(clr_stall)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .BUBBLE_ZERO(1'b1), .CNT_W(16)) u_noskid (
        .clock(clock), .clr(clr), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_data(in_data), .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
        .out_data(n_out_data), .stall_count(n_stall), .clr_stall(clr_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Skid stage holds up to two payloads and only refuses when both are held;
    // the plain stage holds one and accepts whenever its slot frees this cycle.
    function automatic logic rdy_s();
        return q_s.size() < 2;
    endfunction

    function automatic logic rdy_n();
        return out_ready || (q_n.size() == 0);
    endfunction

    task automatic reset_model();
        q_s.delete();
        q_n.delete();
        st_s = 0;
        st_n = 0;
    endtask

    task automatic check_all();
        chk("skid.out_valid", 64'(s_out_valid), 64'(q_s.size() > 0));
        chk("skid.out_data",  64'(s_out_data),  (q_s.size() > 0) ? 64'(q_s[0]) : 64'd0);
        chk("skid.in_ready",  64'(s_in_ready),  64'(rdy_s()));
        chk("skid.stall",     64'(s_stall),     64'(st_s));
        chk("noskid.out_valid", 64'(n_out_valid), 64'(q_n.size() > 0));
        chk("noskid.out_data",  64'(n_out_data),  (q_n.size() > 0) ? 64'(q_n[0]) : 64'd0);
        chk("noskid.in_ready",  64'(n_in_ready),  64'(rdy_n()));
        chk("noskid.stall",     64'(n_stall),     64'(st_n));
    endtask

    task automatic update_model();
        logic ov_s, ov_n, acc_s, acc_n;
        if (!clr) begin
            reset_model();
            return;
        end
        ov_s  = q_s.size() > 0;
        ov_n  = q_n.size() > 0;
        acc_s = in_valid && rdy_s() && !flush;
        acc_n = in_valid && rdy_n() && !flush;
        if (clr_stall) st_s = 0; else if (ov_s && !out_ready && st_s < 15) st_s++;
        if (clr_stall) st_n = 0; else if (ov_n && !out_ready && st_n < 65535) st_n++;
        if (flush) begin
            q_s.delete();
            q_n.delete();
        end else begin
            if (ov_s && out_ready) void'(q_s.pop_front());
            if (ov_n && out_ready) void'(q_n.pop_front());
            if (acc_s) q_s.push_back(in_data);
            if (acc_n) q_n.push_back(in_data);
        end
    endtask

    // One clock cycle: drive at the falling edge, check mid-cycle, advance model at the rising edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic cs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_stall = cs;
        #1;
        check_all();
        @(posedge clock);
        update_model();
        @(negedge clock);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    initial begin
        clr = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0; clr_stall = 1'b0;
        reset_model();
        #1 clr = 1'b0;
        @(negedge clock);

        // Reset held with random input activity.
        for (int i = 0; i < 4; i++)
            step(1'($urandom), rnd_data(), 1'($urandom), 1'($urandom), 1'($urandom));
        clr = 1'b1;
        step(1'b1, 40'hA5, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: A, B, C with out_ready low from the cycle after A.
        step(1'b1, 40'hA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 40'hB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 40'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 40'hC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 40'hC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with both entries held, plus a same-cycle input that must vanish.
        step(1'b1, 40'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 40'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 40'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Counter saturation and clear.
        step(1'b1, 40'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Mid-stream single-cycle out_ready drop.
        for (int i = 0; i < 8; i++) step(1'b1, DW'(32'h100 + i), (i != 4), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);

        // Asynchronous reset between edges while payloads are held.
        step(1'b1, 40'h77, 1'b0, 1'b0, 1'b0);
        step(1'b1, 40'h88, 1'b0, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1 reset_model();
        check_all();
        @(negedge clock);
        step(1'b1, 40'h99, 1'b1, 1'b0, 1'b0);
        clr = 1'b1;
        step(1'b1, 40'h123, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
